// File: rtl/valid_stream_receiver.sv
// rtl/valid_stream_receiver.sv - FWFT receive FIFO for a valid-only pipeline with credit return
module valid_stream_receiver #(
    parameter int width = 8,
    parameter int depth = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_vld,
    input  logic [width-1:0]           in_data,
    output logic                       out_vld,
    output logic [width-1:0]           out_data,
    input  logic                       out_rdy,
    output logic                       credit_ret,
    output logic [$clog2(depth+1)-1:0] count,
    output logic                       full,
    output logic                       overflow
);
    localparam int ptr_w = $clog2(depth);
    localparam int cnt_w = $clog2(depth + 1);

    logic [width-1:0] mem [depth];
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic             drop;

    assign out_vld  = (count != '0);
    assign full     = (count == cnt_w'(depth));
    assign pop      = out_vld && out_rdy;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push     = in_vld && (!full || pop);
    assign drop     = in_vld && full && !pop;
    assign out_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            credit_ret <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ptr_w'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_w'(1);
            end
            count      <= count + cnt_w'(push) - cnt_w'(pop);
            credit_ret <= pop;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule
